spi_mem_loader: RTL and testbench
=================================

Name: spi_mem_loader

Overview:
- Parametrised serial loader/readback engine that replaces the fixed 12-bit shift buffer and the IRECV/DRECV states of the processor control FSM.
- Each frame carries a R/W bit and a start address, followed by a burst of data words; the address auto-increments per word.
- Serves NUM_CH memory targets (icache, dcache, frame counter, ...), each selected by its own active-low chip select.
- Adds burst transfers, readback on miso, and abort/error detection.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; the address wraps modulo 2^ADDR_W.
- NUM_CH, 2, number of chip selects / targets (1..8).

Ports:
- clk  in  1  system clock; all bit sampling is synchronous to clk.
- rst  in  1  reset, synchronous, active-high.
- cs_n  in  NUM_CH  active-low chip selects, one per target.
- bit_vld  in  1  bit strobe; mosi is sampled and miso advances only when bit_vld=1.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial readback, MSB first.
- ch_sel  out  NUM_CH  one-hot active target, held for the whole frame.
- addr  out  ADDR_W  current word address.
- wr_en  out  1  one-cycle write strobe.
- wr_data  out  DATA_W  write word, valid while wr_en=1.
- rd_en  out  1  one-cycle read strobe; target returns rd_data combinationally in the same cycle.
- rd_data  in  DATA_W  read word from the selected target.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at frame end if at least one whole word was transferred.
- err  out  1  one-cycle pulse at frame end if the frame was truncated.

Behaviour:
- Reset: state=IDLE; all outputs 0 (miso, ch_sel, addr, wr_en, wr_data, rd_en, busy, frame_done, err); bit counter 0; shift registers 0. rst mid-frame drops the frame with no wr_en, no frame_done and no err.
- Active line ("sel") = the cs_n bit indicated by ch_sel.
- State IDLE:
  - If any cs_n bit is 0: latch ch_sel = lowest-index low line; clear counters; go to HDR.
  - bit_vld in this cycle is ignored. The master must present the first bit no earlier than 1 clk after cs_n falls.
- State HDR:
  - Each bit_vld shifts mosi in.
  - After 1+ADDR_W bits: bit0 = rw (1=read), remaining bits = start address. Latch addr and go to DATA.
  - If read: in the cycle after the last header bit, rd_en=1 and the out-shifter loads rd_data.
- State DATA, write:
  - Shift DATA_W bits.
  - Cycle after the last bit: wr_en=1 with wr_data and the current addr.
  - Next cycle: addr <= addr+1 (wraps, e.g. 4'hF -> 4'h0).
- State DATA, read:
  - miso = MSB of the out-shifter; the shifter left-shifts on each bit_vld.
  - After DATA_W bits: addr increments; the following cycle rd_en=1 and the shifter reloads (prefetch of the next word).
  - miso=0 outside read DATA.
- Frame end: sel goes high in any non-IDLE state -> next cycle state=IDLE, busy=0, ch_sel=0.
  - frame_done pulses if at least one complete word was transferred.
  - err pulses if header bits or a partial word (bit counter != 0) are pending. The partial word is discarded with no wr_en.
  - frame_done and err may pulse together.
- Changes on non-selected cs_n lines while busy are ignored.
- A strobe (wr_en/rd_en) coinciding with a frame-end cycle still completes.
- Back-to-back frames: IDLE is always visited for at least 1 cycle.
- Bit-to-strobe latency: 1 clk after the final bit_vld of a word.
- wr_data holds its value until the next word completes.

Optional Feature:
- Macro: SPI_LOADER_PARITY_EN.
- Defined:
  - Each data word (write or read direction) is followed by one extra bit (state PAR) carrying even parity over the word.
  - Write: wr_en is asserted after the parity bit, and only if parity matches. On mismatch the word is dropped, err pulses immediately, addr still increments and the frame continues.
  - Read: the engine drives the parity bit on miso after the word.
- Undefined: no PAR state; words are exactly DATA_W bits.

Test Plan:
- Write burst, ch0 (cs_n=2'b10): header rw=0, addr=4'hE, words 8'h11, 8'h22, 8'h33 -> wr_en three times at addr E, F, 0 with those data; ch_sel=2'b01; frame_done=1; err=0.
- Read, ch1: header rw=1, addr=4'h3, rd_data=8'hA5 -> rd_en with addr=3; miso sequence 1,0,1,0,0,1,0,1; then prefetch rd_en at addr=4.
- Abort: write header plus 5 data bits, then cs_n high -> no wr_en, err=1, frame_done=0, busy low 1 clk later.
- Contention: cs_n=2'b00 from IDLE -> ch_sel=2'b01. Releasing cs_n[1] mid-frame has no effect on the frame.
- Reset: rst=1 during DATA -> next clk all outputs 0 and no strobes. A new frame afterwards writes correctly.
- SPI_LOADER_PARITY_EN: word 8'h03 with parity 0 -> wr_en; word 8'h07 with parity 0 -> err, no wr_en, next word lands at addr+2.

Source files
------------

// File: rtl/spi_mem_loader.sv
// Serial frame loader/readback engine: a {rw, addr} header, then a burst of data words per chip select.
// Build macro SPI_LOADER_PARITY_EN appends an even-parity bit (state PAR) to every data word.
module spi_mem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] cs_n,
  input  logic              bit_vld,
  input  logic              mosi,
  output logic              miso,
  output logic [NUM_CH-1:0] ch_sel,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);
  localparam int HDR_W = 1 + ADDR_W;
  localparam int MAX_W = (DATA_W > HDR_W) ? DATA_W : HDR_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

`ifdef SPI_LOADER_PARITY_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] hdr_sh;
  logic [DATA_W-2:0] in_sh;
  logic [DATA_W-1:0] out_sh;
  logic              rw;
  logic              word_seen;
`ifdef SPI_LOADER_PARITY_EN
  logic [DATA_W-1:0] par_word;
`endif

  logic [NUM_CH-1:0] first_low;
  logic              frame_end;
  logic              shift;
  logic              hdr_last;
  logic              word_last;
  logic [HDR_W-1:0]  hdr_next;
  logic [DATA_W-1:0] in_next;

  // Only the latched line can end a frame; other cs_n lines are ignored while busy.
  assign frame_end = (state != IDLE) && ((ch_sel & ~cs_n) == '0);
  assign shift     = bit_vld && (state != IDLE) && !frame_end;
  assign hdr_last  = shift && (state == HDR) && (bit_cnt == HDR_LAST);
  assign word_last = shift && (state == DATA) && (bit_cnt == WORD_LAST);
  assign hdr_next  = {hdr_sh, mosi};
  assign in_next   = {in_sh, mosi};
  assign busy      = (state != IDLE);

  always_comb begin
    first_low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!cs_n[i]) first_low = NUM_CH'(1) << i;
    end
  end

  always_comb begin
    miso = 1'b0;
    if (state == DATA && rw) miso = out_sh[DATA_W-1];
`ifdef SPI_LOADER_PARITY_EN
    else if (state == PAR && rw) miso = ^par_word;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!(&cs_n)) state_nxt = HDR;
      HDR: begin
        if (frame_end)     state_nxt = IDLE;
        else if (hdr_last) state_nxt = DATA;
      end
      DATA: begin
        if (frame_end) state_nxt = IDLE;
`ifdef SPI_LOADER_PARITY_EN
        else if (word_last) state_nxt = PAR;
      end
      PAR: begin
        if (frame_end)  state_nxt = IDLE;
        else if (shift) state_nxt = DATA;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel     <= '0;
      addr       <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      rd_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      bit_cnt    <= '0;
      hdr_sh     <= '0;
      in_sh      <= '0;
      out_sh     <= '0;
      rw         <= 1'b0;
      word_seen  <= 1'b0;
`ifdef SPI_LOADER_PARITY_EN
      par_word   <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;

      // A write strobe advances the address on the cycle after it is presented.
      if (wr_en) addr <= addr + 1'b1;

      if (rd_en) begin
        out_sh <= rd_data;
`ifdef SPI_LOADER_PARITY_EN
        par_word <= rd_data;
`endif
      end else if (shift && state == DATA && rw) begin
        out_sh <= {out_sh[DATA_W-2:0], 1'b0};
      end

      if (state == IDLE) begin
        if (!(&cs_n)) begin
          ch_sel    <= first_low;
          bit_cnt   <= '0;
          hdr_sh    <= '0;
          in_sh     <= '0;
          out_sh    <= '0;
          rw        <= 1'b0;
          word_seen <= 1'b0;
        end
      end else if (frame_end) begin
        ch_sel     <= '0;
        bit_cnt    <= '0;
        frame_done <= word_seen;
        err        <= (bit_cnt != '0);
      end else if (state == HDR && shift) begin
        hdr_sh <= hdr_next[ADDR_W-1:0];
        if (hdr_last) begin
          bit_cnt <= '0;
          rw      <= hdr_next[HDR_W-1];
          addr    <= hdr_next[ADDR_W-1:0];
          rd_en   <= hdr_next[HDR_W-1];
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (state == DATA && shift) begin
        in_sh <= in_next[DATA_W-2:0];
        if (word_last) begin
`ifdef SPI_LOADER_PARITY_EN
          bit_cnt <= bit_cnt + 1'b1;
          if (!rw) par_word <= in_next;
`else
          bit_cnt   <= '0;
          word_seen <= 1'b1;
          if (rw) begin
            addr  <= addr + 1'b1;
            rd_en <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= in_next;
          end
`endif
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
`ifdef SPI_LOADER_PARITY_EN
      else if (state == PAR && shift) begin
        bit_cnt <= '0;
        if (rw) begin
          addr      <= addr + 1'b1;
          rd_en     <= 1'b1;
          word_seen <= 1'b1;
        end else if (mosi == ^par_word) begin
          wr_en     <= 1'b1;
          wr_data   <= par_word;
          word_seen <= 1'b1;
        end else begin
          // Bad word is dropped but still consumes its address slot.
          err  <= 1'b1;
          addr <= addr + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Scoreboard bench for spi_mem_loader: stimulus queues expected strobes/miso bits, a negedge monitor checks them.
module tb_spi_mem_loader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] cs_n;
  logic              bit_vld;
  logic              mosi;
  logic              miso;
  logic [NUM_CH-1:0] ch_sel;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              frame_done;
  logic              err;
  logic              miso_chk;

  logic [DATA_W-1:0] rmem [16];

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [NUM_CH-1:0] ch;
  } wr_t;
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [NUM_CH-1:0] ch;
  } rd_t;
  typedef struct {
    logic fd;
    logic er;
  } fe_t;

  wr_t  wr_q[$];
  rd_t  rd_q[$];
  fe_t  fe_q[$];
  logic mq[$];
  wr_t  we;
  rd_t  re;
  fe_t  fe;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always_comb rd_data = rmem[addr];

  spi_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .bit_vld(bit_vld), .mosi(mosi), .miso(miso),
    .ch_sel(ch_sel), .addr(addr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .busy(busy), .frame_done(frame_done), .err(err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every strobe / checked miso bit must match the head of its queue.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_q.size() == 0) chk("wr_en_unexpected", 32'(wr_en), 0);
      else begin
        we = wr_q.pop_front();
        chk("wr_addr", 32'(addr), 32'(we.a));
        chk("wr_data", 32'(wr_data), 32'(we.d));
        chk("wr_ch_sel", 32'(ch_sel), 32'(we.ch));
      end
    end
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_en_unexpected", 32'(rd_en), 0);
      else begin
        re = rd_q.pop_front();
        chk("rd_addr", 32'(addr), 32'(re.a));
        chk("rd_ch_sel", 32'(ch_sel), 32'(re.ch));
      end
    end
    if (frame_done || err) begin
      if (fe_q.size() == 0) chk("frame_end_unexpected", 32'({frame_done, err}), 0);
      else begin
        fe = fe_q.pop_front();
        chk("frame_done", 32'(frame_done), 32'(fe.fd));
        chk("err", 32'(err), 32'(fe.er));
      end
    end
    if (bit_vld && miso_chk) begin
      if (mq.size() == 0) chk("miso_unexpected_check", 32'(miso_chk), 0);
      else chk("miso", 32'(miso), 32'(mq.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic chkm, input logic expm);
    cyc();
    if (chkm) mq.push_back(expm);
    bit_vld = 1'b1; mosi = b; miso_chk = chkm;
    cyc();
    bit_vld = 1'b0; mosi = 1'b0; miso_chk = 1'b0;
  endtask

  task automatic send_hdr(input logic rw, input logic [ADDR_W-1:0] a);
    send_bit(rw, 1'b0, 1'b0);
    for (int i = ADDR_W - 1; i >= 0; i--) send_bit(a[i], 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i], 1'b0, 1'b0);
`ifdef SPI_LOADER_PARITY_EN
    send_bit(^w, 1'b0, 1'b0);
`endif
  endtask

  task automatic read_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(1'b0, 1'b1, w[i]);
`ifdef SPI_LOADER_PARITY_EN
    send_bit(1'b0, 1'b1, ^w);
`endif
  endtask

  task automatic start_frame(input logic [NUM_CH-1:0] c);
    cyc();
    cs_n = c;
  endtask

  task automatic end_frame();
    cyc();
    cs_n = '1;
    cyc();
    cyc();
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NUM_CH-1:0] c);
    wr_q.push_back('{a, d, c});
  endtask

  task automatic exp_rd(input logic [ADDR_W-1:0] a, input logic [NUM_CH-1:0] c);
    rd_q.push_back('{a, c});
  endtask

  task automatic exp_fe(input logic d, input logic e);
    fe_q.push_back('{d, e});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_miso"}, 32'(miso), 0);
    chk({tag, "_ch_sel"}, 32'(ch_sel), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cs_n = '1; bit_vld = 1'b0; mosi = 1'b0; miso_chk = 1'b0;
    for (int i = 0; i < 16; i++) rmem[i] = '0;
    rmem[3] = 8'hA5;
    rmem[4] = 8'h3C;
    rmem[5] = 8'h0F;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Write burst on ch0 with address wrap E, F, 0.
    start_frame(2'b10);
    send_hdr(1'b0, 4'hE);
    exp_wr(4'hE, 8'h11, 2'b01); send_word(8'h11);
    exp_wr(4'hF, 8'h22, 2'b01); send_word(8'h22);
    exp_wr(4'h0, 8'h33, 2'b01); send_word(8'h33);
    exp_fe(1'b1, 1'b0);
    end_frame();

    // Read on ch1 from address 3, two words plus the trailing prefetch.
    start_frame(2'b01);
    exp_rd(4'h3, 2'b10);
    send_hdr(1'b1, 4'h3);
    exp_rd(4'h4, 2'b10); read_word(8'hA5);
    exp_rd(4'h5, 2'b10); read_word(8'h3C);
    exp_fe(1'b1, 1'b0);
    end_frame();

    // Abort after 5 data bits: no write, err only, busy drops one cycle later.
    start_frame(2'b10);
    send_hdr(1'b0, 4'h5);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    exp_fe(1'b0, 1'b1);
    cyc();
    cs_n = '1;
    @(negedge clk);
    chk("abort_busy_same_cycle", 32'(busy), 1);
    @(negedge clk);
    chk("abort_busy_after", 32'(busy), 0);
    chk("abort_ch_sel_after", 32'(ch_sel), 0);
    cyc();

    // Contention: both lines low selects ch0; releasing cs_n[1] mid-frame is ignored.
    start_frame(2'b00);
    cyc();
    @(negedge clk);
    chk("contention_ch_sel", 32'(ch_sel), 32'(2'b01));
    send_hdr(1'b0, 4'h7);
    exp_wr(4'h7, 8'h5A, 2'b01); send_word(8'h5A);
    cyc();
    cs_n = 2'b10;
    exp_wr(4'h8, 8'hC3, 2'b01); send_word(8'hC3);
    exp_fe(1'b1, 1'b0);
    end_frame();

    // Reset mid-DATA drops the frame; the next frame writes normally.
    start_frame(2'b10);
    send_hdr(1'b0, 4'h6);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    cyc();
    rst = 1'b1; cs_n = '1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midreset");
    cyc();
    rst = 1'b0;
    start_frame(2'b10);
    send_hdr(1'b0, 4'h9);
    exp_wr(4'h9, 8'h96, 2'b01); send_word(8'h96);
    exp_fe(1'b1, 1'b0);
    end_frame();

`ifdef SPI_LOADER_PARITY_EN
    // Parity: good word at A, bad word dropped with err, next good word at C.
    start_frame(2'b10);
    send_hdr(1'b0, 4'hA);
    exp_wr(4'hA, 8'h03, 2'b01);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(8'h03 >> i, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    exp_fe(1'b0, 1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(8'h07 >> i, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    exp_wr(4'hC, 8'h21, 2'b01);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(8'h21 >> i, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    exp_fe(1'b1, 1'b0);
    end_frame();
`endif

    repeat (3) cyc();
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("fe_q_drained", 32'(fe_q.size()), 0);
    chk("miso_q_drained", 32'(mq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
